// File: rtl/csr_mtrap_pkg.sv
// Shared constants, register record and address helpers for the machine-mode
// CSR file and trap controller.
package csr_mtrap_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;  // ..0x32A for mhpmevent10
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;  // ..0xB0A for mhpmcounter10
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;  // ..0xB8A for mhpmcounter10h
  localparam logic [11:0] CSR_HI_OFFSET     = 12'h080;
  localparam int unsigned MAX_HPM           = 8;

  // Machine interrupt cause codes
  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
  localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [31:0] MIE_MASK      = 32'h0000_0888;
  localparam logic [31:0] MTVEC_MASK    = 32'hFFFF_FFFD;

  typedef struct packed {
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mie;
    logic [31:0] mip;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
  } csr_mtrap_reg_type;

  function automatic csr_mtrap_reg_type reg_reset(input logic [31:0] mtvec_init);
    csr_mtrap_reg_type r;
    r       = '0;
    r.mtvec = mtvec_init & MTVEC_MASK;
    return r;
  endfunction

  // Counter index k: 0 = mcycle, 1 = minstret, 2+n = mhpmcounter(3+n).
  function automatic logic [11:0] cnt_lo_addr(input int unsigned k);
    return (k == 0) ? CSR_MCYCLE : CSR_MCYCLE + 12'(k + 1);
  endfunction

  function automatic logic [11:0] cnt_hi_addr(input int unsigned k);
    return cnt_lo_addr(k) + CSR_HI_OFFSET;
  endfunction

endpackage

// File: rtl/csr_mtrap_if.sv
// CSR read/write port between decode/writeback and the machine CSR file.
interface csr_mtrap_if;
  logic        crden;
  logic [11:0] craddr;
  logic [31:0] crdata;
  logic        cwren;
  logic [11:0] cwaddr;
  logic [31:0] cwdata;

  modport master (output crden, craddr, cwren, cwaddr, cwdata, input crdata);
  modport slave  (input crden, craddr, cwren, cwaddr, cwdata, output crdata);
endinterface

// File: rtl/csr_counter.sv
// CNT_WIDTH-wide event counter exposed as two 32-bit CSR halves; a write to
// either half replaces that cycle's increment.
module csr_counter #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic        inc,
  input  logic        inhibit,
  output logic [31:0] rd_lo,
  output logic [31:0] rd_hi
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]          cnt_ext, cnt_wr;
  logic                 wr_hi_eff;

  assign cnt_ext   = 64'(cnt_q);
  assign wr_hi_eff = wr_hi && (CNT_WIDTH > 32);

  // NOTE: every variable gets its default at the top of the block so no path
  // leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    cnt_wr = cnt_ext;
    cnt_d  = cnt_q;
    if (wr_lo)     cnt_wr[31:0]  = wdata;
    if (wr_hi_eff) cnt_wr[63:32] = wdata;
    if (wr_lo || wr_hi_eff) begin
      cnt_d = cnt_wr[CNT_WIDTH-1:0];
    end else if (inc && !inhibit) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign rd_lo = cnt_ext[31:0];
  assign rd_hi = cnt_ext[63:32];

endmodule

// File: rtl/csr_mtrap.sv
// Machine-mode CSR file and trap controller with interrupt arbitration and
// performance counters. Optional mcountinhibit: define CSR_COUNTINHIBIT_EN.
module csr_mtrap
  import csr_mtrap_pkg::*;
#(
  parameter int unsigned CNT_WIDTH   = 64,
  parameter int unsigned NUM_HPM     = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  csr_mtrap_if.slave  bus,
  input  logic        valid,
  input  logic        exception,
  input  logic [3:0]  ecause,
  input  logic [31:0] etval,
  input  logic [31:0] epc,
  input  logic        irq_take,
  input  logic        mret,
  input  logic        ext_irq,
  input  logic        tim_irq,
  input  logic        sw_irq,
  input  logic [7:0]  hpm_event,
  output logic        irq_pending,
  output logic        trap,
  output logic        mret_o,
  output logic [31:0] mepc,
  output logic [31:0] mtvec
);

  localparam int unsigned NCNT      = 2 + NUM_HPM;
  localparam int unsigned HPM_SLOTS = (NUM_HPM > 0) ? NUM_HPM : 1;

  csr_mtrap_reg_type reg_q, reg_d;
  logic              trap_q, trap_d;
  logic              mret_q, mret_d;
  logic [3:0]        mhpmevent_q [HPM_SLOTS];
  logic [3:0]        mhpmevent_d [HPM_SLOTS];

  logic [NCNT-1:0]   cnt_inhibit, cnt_inc, cnt_wr_lo, cnt_wr_hi;
  logic [31:0]       cnt_lo [NCNT];
  logic [31:0]       cnt_hi [NCNT];
  logic [31:0]       mcountinhibit_rd;

  logic [31:0]       irq_active;
  logic [3:0]        irq_code;
  logic              irq_accept;
  logic              trap_event;
  logic [31:0]       mstatus_rd, rdata, mtvec_base;

  // ---------------------------------------------------------------- inhibit
`ifdef CSR_COUNTINHIBIT_EN
  // Stored per counter; CSR bit 1 has no counter behind it.
  logic [NCNT-1:0] inhibit_q, inhibit_d;

  always_comb begin
    inhibit_d = inhibit_q;
    if (bus.cwren && bus.cwaddr == CSR_MCOUNTINHIBIT) begin
      inhibit_d[0] = bus.cwdata[0];
      for (int k = 1; k < NCNT; k++) inhibit_d[k] = bus.cwdata[k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) inhibit_q <= '0;
    else     inhibit_q <= inhibit_d;
  end

  always_comb begin
    mcountinhibit_rd    = '0;
    mcountinhibit_rd[0] = inhibit_q[0];
    for (int k = 1; k < NCNT; k++) mcountinhibit_rd[k+1] = inhibit_q[k];
  end

  assign cnt_inhibit = inhibit_q;
`else
  assign cnt_inhibit      = '0;
  assign mcountinhibit_rd = '0;
`endif

  // ---------------------------------------------------------------- counters
  always_comb begin
    cnt_inc    = '0;
    cnt_inc[0] = 1'b1;
    cnt_inc[1] = valid;
    for (int i = 0; i < NUM_HPM; i++) begin
      cnt_inc[2+i] = mhpmevent_q[i][3] & hpm_event[mhpmevent_q[i][2:0]];
    end
  end

  for (genvar k = 0; k < NCNT; k++) begin : g_cnt
    assign cnt_wr_lo[k] = bus.cwren && (bus.cwaddr == cnt_lo_addr(k));
    assign cnt_wr_hi[k] = bus.cwren && (bus.cwaddr == cnt_hi_addr(k));

    csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .wr_lo   (cnt_wr_lo[k]),
      .wr_hi   (cnt_wr_hi[k]),
      .wdata   (bus.cwdata),
      .inc     (cnt_inc[k]),
      .inhibit (cnt_inhibit[k]),
      .rd_lo   (cnt_lo[k]),
      .rd_hi   (cnt_hi[k])
    );
  end

  // ---------------------------------------------------------------- interrupts
  assign irq_active  = reg_q.mip & reg_q.mie;
  assign irq_pending = reg_q.mstatus_mie & (|irq_active);
  assign irq_accept  = irq_take & irq_pending;
  assign trap_event  = exception | irq_accept;

  always_comb begin
    if      (irq_active[11]) irq_code = IRQ_CODE_MEI;
    else if (irq_active[3])  irq_code = IRQ_CODE_MSI;
    else                     irq_code = IRQ_CODE_MTI;
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    reg_d   = reg_q;
    trap_d  = trap_event;
    mret_d  = mret;
    for (int i = 0; i < HPM_SLOTS; i++) mhpmevent_d[i] = mhpmevent_q[i];

    reg_d.mip     = '0;
    reg_d.mip[11] = ext_irq;
    reg_d.mip[7]  = tim_irq;
    reg_d.mip[3]  = sw_irq;

    if (bus.cwren) begin
      for (int i = 0; i < NUM_HPM; i++) begin
        if (bus.cwaddr == CSR_MHPMEVENT3 + 12'(i)) mhpmevent_d[i] = bus.cwdata[3:0];
      end
      case (bus.cwaddr)
        CSR_MIE:      reg_d.mie      = bus.cwdata & MIE_MASK;
        CSR_MTVEC:    reg_d.mtvec    = bus.cwdata & MTVEC_MASK;
        CSR_MSCRATCH: reg_d.mscratch = bus.cwdata;
        default: ;
      endcase
      // Trap state registers lose to any trap or mret in the same cycle.
      if (!(trap_event || mret)) begin
        case (bus.cwaddr)
          CSR_MSTATUS: begin
            reg_d.mstatus_mie  = bus.cwdata[3];
            reg_d.mstatus_mpie = bus.cwdata[7];
          end
          CSR_MEPC:   reg_d.mepc   = bus.cwdata;
          CSR_MCAUSE: reg_d.mcause = bus.cwdata;
          CSR_MTVAL:  reg_d.mtval  = bus.cwdata;
          default: ;
        endcase
      end
    end

    if (exception) begin
      reg_d.mcause       = {28'b0, ecause};
      reg_d.mepc         = {epc[31:2], 2'b00};
      reg_d.mtval        = etval;
      reg_d.mstatus_mpie = reg_q.mstatus_mie;
      reg_d.mstatus_mie  = 1'b0;
    end else if (irq_accept) begin
      reg_d.mcause       = {1'b1, 27'b0, irq_code};
      reg_d.mepc         = epc;
      reg_d.mtval        = '0;
      reg_d.mstatus_mpie = reg_q.mstatus_mie;
      reg_d.mstatus_mie  = 1'b0;
    end else if (mret) begin
      reg_d.mstatus_mie  = reg_q.mstatus_mpie;
      reg_d.mstatus_mpie = 1'b1;
    end
  end

  // NOTE: mhpmevent is a handful of flops rather than a RAM, so it is reset
  // along with the rest of the architectural state.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q  <= reg_reset(RESET_MTVEC);
      trap_q <= 1'b0;
      mret_q <= 1'b0;
      for (int i = 0; i < HPM_SLOTS; i++) mhpmevent_q[i] <= '0;
    end else begin
      reg_q  <= reg_d;
      trap_q <= trap_d;
      mret_q <= mret_d;
      for (int i = 0; i < HPM_SLOTS; i++) mhpmevent_q[i] <= mhpmevent_d[i];
    end
  end

  // ---------------------------------------------------------------- read port
  always_comb begin
    mstatus_rd    = MSTATUS_FIXED;
    mstatus_rd[3] = reg_q.mstatus_mie;
    mstatus_rd[7] = reg_q.mstatus_mpie;

    rdata = '0;
    case (bus.craddr)
      CSR_MSTATUS:       rdata = mstatus_rd;
      CSR_MISA:          rdata = MISA_VALUE;
      CSR_MIE:           rdata = reg_q.mie;
      CSR_MTVEC:         rdata = reg_q.mtvec;
      CSR_MSCRATCH:      rdata = reg_q.mscratch;
      CSR_MEPC:          rdata = reg_q.mepc;
      CSR_MCAUSE:        rdata = reg_q.mcause;
      CSR_MTVAL:         rdata = reg_q.mtval;
      CSR_MIP:           rdata = reg_q.mip;
      CSR_MCOUNTINHIBIT: rdata = mcountinhibit_rd;
      default: ;
    endcase
    for (int i = 0; i < NUM_HPM; i++) begin
      if (bus.craddr == CSR_MHPMEVENT3 + 12'(i)) rdata = {28'b0, mhpmevent_q[i]};
    end
    for (int k = 0; k < NCNT; k++) begin
      if (bus.craddr == cnt_lo_addr(k)) rdata = cnt_lo[k];
      if (bus.craddr == cnt_hi_addr(k)) rdata = cnt_hi[k];
    end
    if (!bus.crden) rdata = '0;
  end

  assign bus.crdata = rdata;

  // ---------------------------------------------------------------- outputs
  assign mtvec_base = {reg_q.mtvec[31:2], 2'b00};
  assign mtvec      = (reg_q.mtvec[0] && reg_q.mcause[31])
                    ? mtvec_base + {26'b0, reg_q.mcause[3:0], 2'b00}
                    : mtvec_base;
  assign mepc       = reg_q.mepc;
  assign trap       = trap_q;
  assign mret_o     = mret_q;

endmodule

// File: tb/tb_csr_mtrap.sv
// Directed bench for csr_mtrap: a 64-bit/4-HPM instance carries most tests,
// a 40-bit/0-HPM instance covers narrow counters and the mtvec reset value.
module tb_csr_mtrap;
  import csr_mtrap_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid, exception, irq_take, mret, ext_irq, tim_irq, sw_irq;
  logic [3:0]  ecause;
  logic [31:0] etval, epc;
  logic [7:0]  hpm_event;
  logic        irq_pending, trap, mret_o;
  logic [31:0] mepc, mtvec;
  logic        p40, t40, m40;
  logic [31:0] mepc40, mtvec40;

  int n_tests = 0;
  int n_fail  = 0;

  csr_mtrap_if bus ();
  csr_mtrap_if bus40 ();

  csr_mtrap #(.CNT_WIDTH(64), .NUM_HPM(4), .RESET_MTVEC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .valid(valid), .exception(exception),
    .ecause(ecause), .etval(etval), .epc(epc), .irq_take(irq_take), .mret(mret),
    .ext_irq(ext_irq), .tim_irq(tim_irq), .sw_irq(sw_irq), .hpm_event(hpm_event),
    .irq_pending(irq_pending), .trap(trap), .mret_o(mret_o), .mepc(mepc), .mtvec(mtvec)
  );

  csr_mtrap #(.CNT_WIDTH(40), .NUM_HPM(0), .RESET_MTVEC(32'h200)) dut40 (
    .clk(clk), .rst(rst), .bus(bus40), .valid(1'b0), .exception(1'b0),
    .ecause(4'd0), .etval(32'd0), .epc(32'd0), .irq_take(1'b0), .mret(1'b0),
    .ext_irq(1'b0), .tim_irq(1'b0), .sw_irq(1'b0), .hpm_event(8'hFF),
    .irq_pending(p40), .trap(t40), .mret_o(m40), .mepc(mepc40), .mtvec(mtvec40)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.cwren = 1'b1; bus.cwaddr = a; bus.cwdata = d;
    cyc();
    bus.cwren = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.crden = 1'b1; bus.craddr = a;
    #1 d = bus.crdata;
    bus.crden = 1'b0;
  endtask

  task automatic wr40(input logic [11:0] a, input logic [31:0] d);
    bus40.cwren = 1'b1; bus40.cwaddr = a; bus40.cwdata = d;
    cyc();
    bus40.cwren = 1'b0;
  endtask

  task automatic rd40(input logic [11:0] a, output logic [31:0] d);
    bus40.crden = 1'b1; bus40.craddr = a;
    #1 d = bus40.crdata;
    bus40.crden = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    cyc(); cyc();
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b exp 0", trap); end
    n_tests++; if (mret_o !== 1'b0) begin n_fail++; $display("FAIL reset_mret_o: got %b exp 0", mret_o); end
    n_tests++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL reset_irq_pending: got %b exp 0", irq_pending); end
    n_tests++; if (mtvec40 !== 32'h200) begin n_fail++; $display("FAIL reset_mtvec40: got %h exp 00000200", mtvec40); end
    rd(CSR_MSTATUS, d);
    n_tests++; if (d !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus: got %h exp 00001800", d); end
    rd(CSR_MISA, d);
    n_tests++; if (d !== 32'h4000_0100) begin n_fail++; $display("FAIL reset_misa: got %h exp 40000100", d); end
    rd(CSR_MCAUSE, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mcause: got %h exp 0", d); end
    rd(CSR_MCYCLE, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mcycle: got %h exp 0", d); end
    bus.craddr = CSR_MISA; bus.crden = 1'b0;
    #1;
    n_tests++; if (bus.crdata !== 32'h0) begin n_fail++; $display("FAIL crden_low: got %h exp 0", bus.crdata); end
    rst = 1'b0;
  endtask

  task automatic test_mstatus_warl();
    logic [31:0] d;
    wr(CSR_MSTATUS, 32'hFFFF_FFFF);
    rd(CSR_MSTATUS, d);
    n_tests++; if (d !== 32'h1888) begin n_fail++; $display("FAIL mstatus_warl: got %h exp 00001888", d); end
    wr(CSR_MISA, 32'h0);
    rd(CSR_MISA, d);
    n_tests++; if (d !== 32'h4000_0100) begin n_fail++; $display("FAIL misa_ro: got %h exp 40000100", d); end
    rd(12'h7C0, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL unimpl_read: got %h exp 0", d); end
    wr(CSR_MIE, 32'hFFFF_FFFF);
    rd(CSR_MIE, d);
    n_tests++; if (d !== 32'h888) begin n_fail++; $display("FAIL mie_warl: got %h exp 00000888", d); end
    wr(CSR_MTVEC, 32'h103);
    rd(CSR_MTVEC, d);
    n_tests++; if (d !== 32'h101) begin n_fail++; $display("FAIL mtvec_bit1: got %h exp 00000101", d); end
  endtask

  task automatic test_timer_irq();
    logic [31:0] d;
    wr(CSR_MIE, 32'h80);
    wr(CSR_MSTATUS, 32'h8);
    tim_irq = 1'b1;
    #1;
    n_tests++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %b exp 0", irq_pending); end
    cyc();
    n_tests++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL tim_pending: got %b exp 1", irq_pending); end
    rd(CSR_MIP, d);
    n_tests++; if (d !== 32'h80) begin n_fail++; $display("FAIL mip_mti: got %h exp 00000080", d); end
    irq_take = 1'b1; epc = 32'h40;
    cyc();
    irq_take = 1'b0; epc = 32'h0;
    n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL tim_trap: got %b exp 1", trap); end
    rd(CSR_MCAUSE, d);
    n_tests++; if (d !== 32'h8000_0007) begin n_fail++; $display("FAIL tim_mcause: got %h exp 80000007", d); end
    n_tests++; if (mepc !== 32'h40) begin n_fail++; $display("FAIL tim_mepc: got %h exp 00000040", mepc); end
    n_tests++; if (mtvec !== 32'h11C) begin n_fail++; $display("FAIL tim_mtvec: got %h exp 0000011c", mtvec); end
    rd(CSR_MSTATUS, d);
    n_tests++; if (d !== 32'h1880) begin n_fail++; $display("FAIL tim_mstatus: got %h exp 00001880", d); end
    n_tests++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL tim_masked: got %b exp 0", irq_pending); end
    cyc();
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL trap_pulse: got %b exp 0", trap); end
    tim_irq = 1'b0;
  endtask

  task automatic test_priority_mret();
    logic [31:0] d;
    wr(CSR_MIE, 32'h880);
    wr(CSR_MSTATUS, 32'h8);
    ext_irq = 1'b1; tim_irq = 1'b1;
    cyc();
    n_tests++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL ext_pending: got %b exp 1", irq_pending); end
    irq_take = 1'b1; epc = 32'h44;
    cyc();
    irq_take = 1'b0; ext_irq = 1'b0; tim_irq = 1'b0;
    rd(CSR_MCAUSE, d);
    n_tests++; if (d !== 32'h8000_000B) begin n_fail++; $display("FAIL mei_over_mti: got %h exp 8000000b", d); end
    n_tests++; if (mtvec !== 32'h12C) begin n_fail++; $display("FAIL mei_vector: got %h exp 0000012c", mtvec); end
    mret = 1'b1;
    cyc();
    mret = 1'b0;
    n_tests++; if (mret_o !== 1'b1) begin n_fail++; $display("FAIL mret_pulse: got %b exp 1", mret_o); end
    rd(CSR_MSTATUS, d);
    n_tests++; if (d !== 32'h1888) begin n_fail++; $display("FAIL mret_mstatus: got %h exp 00001888", d); end
    cyc();
    n_tests++; if (mret_o !== 1'b0) begin n_fail++; $display("FAIL mret_single: got %b exp 0", mret_o); end
    n_tests++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL lines_low: got %b exp 0", irq_pending); end
    irq_take = 1'b1; epc = 32'h99;
    cyc();
    irq_take = 1'b0;
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL spurious_take: got %b exp 0", trap); end
    rd(CSR_MCAUSE, d);
    n_tests++; if (d !== 32'h8000_000B) begin n_fail++; $display("FAIL spurious_mcause: got %h exp 8000000b", d); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    tim_irq = 1'b1;
    cyc();
    n_tests++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL exc_pre_pending: got %b exp 1", irq_pending); end
    exception = 1'b1; ecause = 4'd2; epc = 32'h83; etval = 32'hDEAD; irq_take = 1'b1;
    bus.cwren = 1'b1; bus.cwaddr = CSR_MEPC; bus.cwdata = 32'h0;
    cyc();
    exception = 1'b0; irq_take = 1'b0; bus.cwren = 1'b0; tim_irq = 1'b0; epc = 32'h0;
    n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL exc_trap: got %b exp 1", trap); end
    rd(CSR_MCAUSE, d);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL exc_mcause: got %h exp 00000002", d); end
    n_tests++; if (mepc !== 32'h80) begin n_fail++; $display("FAIL exc_mepc: got %h exp 00000080", mepc); end
    rd(CSR_MTVAL, d);
    n_tests++; if (d !== 32'hDEAD) begin n_fail++; $display("FAIL exc_mtval: got %h exp 0000dead", d); end
    n_tests++; if (mtvec !== 32'h100) begin n_fail++; $display("FAIL exc_mtvec: got %h exp 00000100", mtvec); end
    rd(CSR_MSTATUS, d);
    n_tests++; if (d !== 32'h1880) begin n_fail++; $display("FAIL exc_mstatus: got %h exp 00001880", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    bus.cwren = 1'b1; bus.cwaddr = CSR_MSCRATCH; bus.cwdata = 32'h1234_ABCD;
    bus.crden = 1'b1; bus.craddr = CSR_MSCRATCH;
    #1 d = bus.crdata;
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rd_old_value: got %h exp 0", d); end
    cyc();
    bus.cwren = 1'b0;
    #1 d = bus.crdata;
    bus.crden = 1'b0;
    n_tests++; if (d !== 32'h1234_ABCD) begin n_fail++; $display("FAIL rd_new_value: got %h exp 1234abcd", d); end
    mret = 1'b1; bus.cwren = 1'b1; bus.cwaddr = CSR_MSTATUS; bus.cwdata = 32'h0;
    cyc();
    mret = 1'b0; bus.cwren = 1'b0;
    rd(CSR_MSTATUS, d);
    n_tests++; if (d !== 32'h1888) begin n_fail++; $display("FAIL mret_over_write: got %h exp 00001888", d); end
  endtask

  task automatic test_counters();
    logic [31:0] d;
    wr(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr(CSR_MCYCLEH, 32'h0);
    cyc();
    rd(CSR_MCYCLEH, d);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL mcycle_carry_hi: got %h exp 00000001", d); end
    rd(CSR_MCYCLE, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL mcycle_carry_lo: got %h exp 0", d); end
    valid = 1'b1;
    wr(CSR_MINSTRET, 32'h0);
    repeat (3) cyc();
    valid = 1'b0;
    rd(CSR_MINSTRET, d);
    n_tests++; if (d !== 32'h3) begin n_fail++; $display("FAIL minstret: got %h exp 00000003", d); end
    wr(CSR_MHPMEVENT3, 32'hFFFF_FFFD);
    wr(CSR_MHPMEVENT3 + 12'd1, 32'h1);
    wr(CSR_MHPMCOUNTER3, 32'h0);
    wr(CSR_MHPMCOUNTER3 + 12'd1, 32'h0);
    hpm_event = 8'h22;
    repeat (4) cyc();
    hpm_event = 8'h02;
    repeat (2) cyc();
    hpm_event = 8'h00;
    rd(CSR_MHPMEVENT3, d);
    n_tests++; if (d !== 32'hD) begin n_fail++; $display("FAIL mhpmevent_warl: got %h exp 0000000d", d); end
    rd(CSR_MHPMCOUNTER3, d);
    n_tests++; if (d !== 32'h4) begin n_fail++; $display("FAIL hpm3_count: got %h exp 00000004", d); end
    rd(CSR_MHPMCOUNTER3 + 12'd1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL hpm4_disabled: got %h exp 0", d); end
  endtask

  task automatic test_count_inhibit();
    logic [31:0] d;
    logic [31:0] exp_mask, exp_inh, exp_cyc, exp_ret;
`ifdef CSR_COUNTINHIBIT_EN
    exp_mask = 32'h7D; exp_inh = 32'h5; exp_cyc = 32'd0;  exp_ret = 32'd0;
`else
    exp_mask = 32'h0;  exp_inh = 32'h0; exp_cyc = 32'd12; exp_ret = 32'd10;
`endif
    wr(CSR_MCOUNTINHIBIT, 32'hFFFF_FFFF);
    rd(CSR_MCOUNTINHIBIT, d);
    n_tests++; if (d !== exp_mask) begin n_fail++; $display("FAIL inhibit_mask: got %h exp %h", d, exp_mask); end
    wr(CSR_MCOUNTINHIBIT, 32'h5);
    rd(CSR_MCOUNTINHIBIT, d);
    n_tests++; if (d !== exp_inh) begin n_fail++; $display("FAIL inhibit_read: got %h exp %h", d, exp_inh); end
    wr(CSR_MCYCLE, 32'h0);
    wr(CSR_MINSTRET, 32'h0);
    wr(CSR_MHPMCOUNTER3, 32'h0);
    valid = 1'b1; hpm_event = 8'h20;
    repeat (10) cyc();
    valid = 1'b0; hpm_event = 8'h00;
    rd(CSR_MCYCLE, d);
    n_tests++; if (d !== exp_cyc) begin n_fail++; $display("FAIL inhibit_mcycle: got %h exp %h", d, exp_cyc); end
    rd(CSR_MINSTRET, d);
    n_tests++; if (d !== exp_ret) begin n_fail++; $display("FAIL inhibit_minstret: got %h exp %h", d, exp_ret); end
    rd(CSR_MHPMCOUNTER3, d);
    n_tests++; if (d !== 32'd10) begin n_fail++; $display("FAIL inhibit_hpm3: got %h exp 0000000a", d); end
    wr(CSR_MCOUNTINHIBIT, 32'h0);
  endtask

  task automatic test_cnt40();
    logic [31:0] d;
    wr40(CSR_MCYCLE, 32'hFFFF_FFFF);
    wr40(CSR_MCYCLEH, 32'hFFFF_FFFF);
    rd40(CSR_MCYCLEH, d);
    n_tests++; if (d !== 32'hFF) begin n_fail++; $display("FAIL cnt40_hi_mask: got %h exp 000000ff", d); end
    rd40(CSR_MCYCLE, d);
    n_tests++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cnt40_lo_max: got %h exp ffffffff", d); end
    cyc();
    rd40(CSR_MCYCLE, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL cnt40_wrap_lo: got %h exp 0", d); end
    rd40(CSR_MCYCLEH, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL cnt40_wrap_hi: got %h exp 0", d); end
    wr40(CSR_MHPMEVENT3, 32'hF);
    rd40(CSR_MHPMEVENT3, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL nohpm_event: got %h exp 0", d); end
    rd40(CSR_MHPMCOUNTER3, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL nohpm_counter: got %h exp 0", d); end
  endtask

  task automatic test_reset_mid_trap();
    logic [31:0] d;
    exception = 1'b1; ecause = 4'd5; epc = 32'h10; rst = 1'b1;
    cyc();
    exception = 1'b0;
    n_tests++; if (trap !== 1'b0) begin n_fail++; $display("FAIL rst_trap: got %b exp 0", trap); end
    rd(CSR_MCAUSE, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mcause: got %h exp 0", d); end
    rd(CSR_MSTATUS, d);
    n_tests++; if (d !== 32'h1800) begin n_fail++; $display("FAIL rst_mstatus: got %h exp 00001800", d); end
    n_tests++; if (mtvec !== 32'h0) begin n_fail++; $display("FAIL rst_mtvec: got %h exp 0", mtvec); end
    rd(CSR_MHPMCOUNTER3, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_hpm3: got %h exp 0", d); end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid = 1'b0; exception = 1'b0; irq_take = 1'b0; mret = 1'b0;
    ext_irq = 1'b0; tim_irq = 1'b0; sw_irq = 1'b0;
    ecause = 4'd0; etval = 32'h0; epc = 32'h0; hpm_event = 8'h0;
    bus.crden = 1'b0; bus.craddr = '0; bus.cwren = 1'b0; bus.cwaddr = '0; bus.cwdata = '0;
    bus40.crden = 1'b0; bus40.craddr = '0; bus40.cwren = 1'b0; bus40.cwaddr = '0; bus40.cwdata = '0;

    test_reset();
    test_mstatus_warl();
    test_timer_irq();
    test_priority_mret();
    test_exception();
    test_back_to_back();
    test_counters();
    test_count_inhibit();
    test_cnt40();
    test_reset_mid_trap();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
